// File: rtl/cache_way_data_array_pkg.sv
// Shared definitions for the cache data path: line/word types, request struct, FSM state.
package cache_def_pipe_data;

  localparam int unsigned SET_NUM_DEF    = 32;
  localparam int unsigned WAYS_DEF       = 4;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned WORD_W_DEF     = 32;
  localparam int unsigned IDX_W_DEF      = $clog2(SET_NUM_DEF);
  localparam int unsigned WOFF_W_DEF     = $clog2(LINE_WORDS_DEF);

  typedef logic [WORD_W_DEF-1:0]                word_t;
  typedef logic [LINE_WORDS_DEF*WORD_W_DEF-1:0] line_t;

  typedef struct packed {
    logic                    we;
    logic                    line;
    logic [IDX_W_DEF-1:0]    index;
    logic [WAYS_DEF-1:0]     way;
    logic [WOFF_W_DEF-1:0]   word;
    logic [WORD_W_DEF/8-1:0] be;
    word_t                   wdata;
  } req_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Even parity: stored bit makes the 9-bit lane XOR to zero.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cache_way_data_array_if.sv
// Request / read-response bundle between the cache controller and the way data array.
interface cache_way_data_array_if
  import cache_def_pipe_data::*;
#(
  parameter int unsigned SET_NUM    = SET_NUM_DEF,
  parameter int unsigned WAYS       = WAYS_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned WORD_W     = WORD_W_DEF
) ();
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_we;
  logic                              req_line;
  logic [$clog2(SET_NUM)-1:0]        req_index;
  logic [WAYS-1:0]                   req_way;
  logic [$clog2(LINE_WORDS)-1:0]     req_word;
  logic [WORD_W/8-1:0]               req_be;
  logic [WORD_W-1:0]                 req_wdata;
  logic [LINE_WORDS*WORD_W-1:0]      req_line_wdata;
  logic                              rd_valid;
  logic [WAYS*LINE_WORDS*WORD_W-1:0] rd_data;
  logic                              init_done;
  logic [WAYS-1:0]                   par_err;

  modport master (
    output req_valid, req_we, req_line, req_index, req_way, req_word,
           req_be, req_wdata, req_line_wdata,
    input  req_ready, rd_valid, rd_data, init_done, par_err
  );

  modport slave (
    input  req_valid, req_we, req_line, req_index, req_way, req_word,
           req_be, req_wdata, req_line_wdata,
    output req_ready, rd_valid, rd_data, init_done, par_err
  );
endinterface

// File: rtl/cache_way_data_array_bank.sv
// Single-port RAM bank with per-lane write enables and a registered 1-cycle read port.
module cache_data_bank #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [LANES-1:0]        wr_en,
  input  logic [AW-1:0]           addr,
  input  logic [LANES*LANE_W-1:0] wdata,
  output logic [LANES*LANE_W-1:0] rdata
);
  logic [LANES*LANE_W-1:0] mem_q [DEPTH];
  logic [LANES*LANE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem_q[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)       rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/cache_way_data_array.sv
// N-way cache data array with post-reset zeroing sweep.
// Optional per-byte even parity enabled by defining CACHE_DATA_PARITY_EN.
module cache_way_data_array
  import cache_def_pipe_data::*;
#(
  parameter int unsigned SET_NUM    = SET_NUM_DEF,
  parameter int unsigned WAYS       = WAYS_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned WORD_W     = WORD_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  cache_way_data_array_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(SET_NUM);
  localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
  localparam int unsigned WORD_B = WORD_W / 8;
  localparam int unsigned LINE_B = LINE_WORDS * WORD_B;
`ifdef CACHE_DATA_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;
  logic                                 rd_valid_q, rd_valid_d;
  logic                                 sweep, accept, rd_en;
  logic [IDX_W-1:0]                     bank_addr;
  logic [LINE_B-1:0]                    lane_be;
  logic [LINE_B*LANE_W-1:0]             bank_wdata;
  logic [WAYS-1:0][LINE_B*LANE_W-1:0]   bank_rdata;
  logic [WAYS*LINE_WORDS*WORD_W-1:0]    rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    sweep      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      INIT: begin
        sweep = rst;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SET_NUM - 1)) state_d = READY;
      end
      READY: begin
        accept     = rst & bus.req_valid;
        rd_valid_d = accept & ~bus.req_we;
      end
      default: state_d = INIT;
    endcase
  end

  assign rd_en = accept & ~bus.req_we;

  // A line write enables every lane; a word write only the lanes of req_word under req_be.
  always_comb begin
    bank_addr  = sweep ? cnt_q : bus.req_index;
    lane_be    = '0;
    bank_wdata = '0;
    for (int unsigned i = 0; i < LINE_B; i++) begin
      logic [7:0] d;
      d = bus.req_line ? bus.req_line_wdata[8*i +: 8] : bus.req_wdata[8*(i % WORD_B) +: 8];
      if (sweep) d = '0;
      lane_be[i] = sweep | bus.req_line |
                   ((bus.req_word == WOFF_W'(i / WORD_B)) & bus.req_be[i % WORD_B]);
`ifdef CACHE_DATA_PARITY_EN
      bank_wdata[i*LANE_W +: LANE_W] = {even_par(d), d};
`else
      bank_wdata[i*LANE_W +: LANE_W] = d;
`endif
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = sweep | (accept & bus.req_we & bus.req_way[w]);

    cache_data_bank #(
      .DEPTH  (SET_NUM),
      .LANES  (LINE_B),
      .LANE_W (LANE_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .wr_en (lane_be & {LINE_B{way_we}}),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[w])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      for (int unsigned i = 0; i < LINE_B; i++) begin
        rd_data[(w*LINE_B + i)*8 +: 8] = bank_rdata[w][i*LANE_W +: 8];
      end
    end
  end

`ifdef CACHE_DATA_PARITY_EN
  logic [WAYS-1:0] perr;
  always_comb begin
    perr = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      for (int unsigned i = 0; i < LINE_B; i++) begin
        perr[w] = perr[w] | (^bank_rdata[w][i*LANE_W +: LANE_W]);
      end
    end
  end
  assign bus.par_err = rd_valid_q ? perr : '0;
`else
  assign bus.par_err = '0;
`endif

  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.req_ready = (state_q == READY);
  assign bus.init_done = (state_q == READY);
endmodule
